fifo_port_arbiter: RTL and testbench

Round-robin arbiter that merges `num_ports` FIFO source streams into a single FIFO destination stream. Each stream uses ready/enable/data signalling, and ports are granted in bursts of up to `max_burst` words. Every output word carries the index of the port it came from. The block sits between per-converter-slot FIFO breakout arrays and a shared downstream consumer, such as the host-bound packetizer.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_priority_select.sv | 30 +++
 rtl/fifo_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE spends one cycle choosing a port, BURST moves words.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of a port index; at least one bit even for a single port.
  function automatic int port_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: finds the first requester after last_grant.
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int num_ports = 2,
  localparam int port_width = port_idx_width(num_ports)
) (
  input  logic [num_ports-1:0]  req_i,
  input  logic [port_width-1:0] last_grant_i,
  output logic                  any_o,
  output logic [port_width-1:0] sel_o
);

  logic [port_width-1:0] idx;

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    any_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int k = num_ports; k >= 1; k--) begin
      idx = port_width'((int'(last_grant_i) + k) % num_ports);
      if (req_i[idx]) begin
        any_o = 1'b1;
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Round-robin burst arbiter merging num_ports FIFO streams into one tagged stream.
//
// Handshake: every stream uses ready/enable. A word moves on a rising edge
// where ready and enable are both high; the sender holds enable/data at its
// own discretion, and ready never depends on the same side's enable.
module fifo_port_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int width     = 8,
  parameter int num_ports = 2,
  parameter int max_burst = 16,
  localparam int port_width  = port_idx_width(num_ports),
  localparam int count_width = $clog2(max_burst + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  output logic [num_ports-1:0]              in_ready,
  input  logic [num_ports-1:0]              in_enable,
  input  logic [num_ports-1:0][width-1:0]   in_data,
  input  logic                              out_ready,
  output logic                              out_enable,
  output logic [width-1:0]                  out_data,
  output logic [port_width-1:0]             out_port,
  output logic                              busy,
  output arb_state_t                        dbg_state,
  output logic [port_width-1:0]             dbg_grant,
  output logic [count_width-1:0]            dbg_count
);

  arb_state_t              state_q;
  logic [port_width-1:0]   grant_q;
  logic [port_width-1:0]   last_grant_q;
  logic [count_width-1:0]  count_q;
  logic [count_width-1:0]  count_d;
  logic                    out_enable_q;
  logic [width-1:0]        out_data_q;
  logic [port_width-1:0]   out_port_q;

  logic                    any_req;
  logic [port_width-1:0]   sel;
  logic                    out_free;
  logic                    grant_en;
  logic [width-1:0]        grant_data;
  logic                    in_xfer;
  logic                    burst_last;

  rr_priority_select #(
    .num_ports (num_ports)
  ) u_sel (
    .req_i        (in_enable),
    .last_grant_i (last_grant_q),
    .any_o        (any_req),
    .sel_o        (sel)
  );

  // The output register can take a new word when empty or being drained.
  assign out_free   = !out_enable_q || out_ready;
  assign in_xfer    = (state_q == BURST) && out_free && grant_en;
  assign count_d    = count_q + 1'b1;
  assign burst_last = (count_q == count_width'(max_burst - 1));

  // Mux the granted port's enable and data.
  always_comb begin
    grant_en   = 1'b0;
    grant_data = '0;
    for (int g = 0; g < num_ports; g++) begin
      if (grant_q == port_width'(g)) begin
        grant_en   = in_enable[g];
        grant_data = in_data[g];
      end
    end
  end

  // Only the granted port sees ready, and only when the output can take a word.
  always_comb begin
    in_ready = '0;
    for (int g = 0; g < num_ports; g++) begin
      in_ready[g] = (state_q == BURST) && (grant_q == port_width'(g)) && out_free;
    end
  end

  // Arbitration FSM: pick a port in IDLE, stream up to max_burst words in BURST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= port_width'(num_ports - 1);
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= sel;
            count_q <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          // A stalled output holds everything; otherwise move a word or end on a bubble.
          if (out_free) begin
            if (grant_en) begin
              count_q <= count_d;
              if (burst_last) begin
                state_q      <= IDLE;
                last_grant_q <= grant_q;
              end
            end else begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: load on input transfer, otherwise clear valid once drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_enable_q <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
    end else if (in_xfer) begin
      out_enable_q <= 1'b1;
      out_data_q   <= grant_data;
      out_port_q   <= grant_q;
    end else if (out_enable_q && out_ready) begin
      out_enable_q <= 1'b0;
    end
  end

  assign out_enable = out_enable_q;
  assign out_data   = out_data_q;
  assign out_port   = out_port_q;
  assign busy       = (state_q == BURST);
  assign dbg_state  = state_q;
  assign dbg_grant  = grant_q;
  assign dbg_count  = count_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: 4 ports, bursts of 4, behavioural model plus directed pins.
module tb_fifo_port_arbiter;
  import fifo_arb_pkg::*;

  localparam int W  = 8;
  localparam int NP = 4;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NP-1:0]        in_ready;
  logic [NP-1:0]        in_enable;
  logic [NP-1:0][W-1:0] in_data;
  logic                 out_ready;
  logic                 out_enable;
  logic [W-1:0]         out_data;
  logic [1:0]           out_port;
  logic                 busy;
  arb_state_t           dbg_state;
  logic [1:0]           dbg_grant;
  logic [2:0]           dbg_count;

  fifo_port_arbiter #(
    .width     (W),
    .num_ports (NP),
    .max_burst (MB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_ready   (in_ready),
    .in_enable  (in_enable),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_enable (out_enable),
    .out_data   (out_data),
    .out_port   (out_port),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_grant  (dbg_grant),
    .dbg_count  (dbg_count)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Source word for port p, sequence number s: port 0 starts with 0x11,0x22,0x33.
  function automatic logic [W-1:0] src_word(input int p, input int s);
    logic [W-1:0] w;
    if (p == 0 && s < 3) w = 8'(17 * (s + 1));
    else                 w = {2'(p), 6'(s)};
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  // A burst owner, words taken in this burst, and the one-word output buffer.
  bit         m_burst;
  int         m_grant, m_last, m_cnt, m_op, m_pick;
  bit         m_ov, m_free, m_take;
  logic [W-1:0] m_od;

  function automatic logic [NP-1:0] m_in_ready();
    logic [NP-1:0] r = '0;
    if (m_burst && (!m_ov || out_ready)) r[m_grant] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_burst = 0; m_grant = 0; m_last = NP - 1; m_cnt = 0;
      m_ov = 0; m_od = '0; m_op = 0;
    end else begin
      m_free = !m_ov || out_ready;
      m_take = m_burst && m_free && in_enable[m_grant];
      if (m_take) begin
        m_ov = 1; m_od = in_data[m_grant]; m_op = m_grant;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (!m_burst) begin
        m_pick = -1;
        for (int k = 1; k <= NP; k++)
          if (m_pick < 0 && in_enable[(m_last + k) % NP]) m_pick = (m_last + k) % NP;
        if (m_pick >= 0) begin
          m_burst = 1; m_grant = m_pick; m_cnt = 0;
        end
      end else if (m_free) begin
        if (m_take) begin
          m_cnt++;
          if (m_cnt == MB) begin m_burst = 0; m_last = m_grant; end
        end else begin
          m_burst = 0; m_last = m_grant;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int src_seq[NP];
  int exp_seq[NP];

  always @(negedge clk) begin
    chk("out_enable", out_enable, m_ov);
    chk("out_data",   out_data,   m_od);
    chk("out_port",   out_port,   m_op);
    chk("busy",       busy,       m_burst);
    chk("state",      dbg_state,  m_burst ? BURST : IDLE);
    chk("in_ready",   in_ready,   m_in_ready());
    chk("count",      dbg_count,  m_cnt);
    if (m_burst) chk("grant", dbg_grant, m_grant);
    // Per-port order: every consumed word is the next one its source sent.
    if (reset_n && out_enable && out_ready) begin
      chk("order", out_data, src_word(out_port, exp_seq[out_port]));
      exp_seq[out_port]++;
    end
  end

  // ---------------- driver ----------------
  int en_mode[NP];   // 0 off, 1 always, 2 random, 3 until en_lim words sent
  int en_lim[NP];
  int or_mode;       // 0 stall, 1 always ready, 2 random
  logic [NP-1:0] hs;

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      in_data[p] = src_word(p, src_seq[p]);
      case (en_mode[p])
        1:       in_enable[p] = 1'b1;
        2:       in_enable[p] = ($urandom_range(0, 3) != 0);
        3:       in_enable[p] = (src_seq[p] < en_lim[p]);
        default: in_enable[p] = 1'b0;
      endcase
    end
    case (or_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  // One clock: note handshakes mid-cycle, then advance sources after the edge.
  task automatic cycle();
    @(negedge clk); #1;
    hs = in_ready & in_enable;
    @(posedge clk); #2;
    for (int p = 0; p < NP; p++) if (hs[p]) src_seq[p]++;
    drive_inputs();
  endtask

  task automatic all_off();
    for (int p = 0; p < NP; p++) en_mode[p] = 0;
    drive_inputs();
  endtask

  int guard;
  logic exp_en[12]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
  int   exp_prt[12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_enable = '0; in_data = '0; out_ready = 1'b0;
    or_mode = 1;
    for (int p = 0; p < NP; p++) begin
      en_mode[p] = 0; en_lim[p] = 0; src_seq[p] = 0; exp_seq[p] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_enable", out_enable, 1'b0);
    chk("rst_out_data",   out_data,   8'h00);
    chk("rst_out_port",   out_port,   2'd0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_in_ready",   in_ready,   4'h0);

    // Single-port stream: one IDLE cycle, then 0x11, 0x22, 0x33 back to back.
    reset_n = 1'b1;
    en_mode[0] = 3; en_lim[0] = 3;
    drive_inputs();
    cycle();
    chk("sp_busy",   busy,       1'b1);
    chk("sp_empty",  out_enable, 1'b0);
    cycle();
    chk("sp_w0_en",  out_enable, 1'b1);
    chk("sp_w0",     out_data,   8'h11);
    chk("sp_w0_prt", out_port,   2'd0);
    cycle();
    chk("sp_w1",     out_data,   8'h22);
    cycle();
    chk("sp_w2",     out_data,   8'h33);
    chk("sp_w2_prt", out_port,   2'd0);
    cycle();
    cycle();
    chk("sp_idle",   busy,       1'b0);

    // Fair bursting: ports 0 and 1 always ready to send, bursts of 4.
    en_mode[0] = 1; en_mode[1] = 1;
    drive_inputs();
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk($sformatf("fair_en_%0d", i), out_enable, exp_en[i]);
      if (exp_en[i]) chk($sformatf("fair_port_%0d", i), out_port, exp_prt[i]);
    end

    // Backpressure mid-burst: word and count must freeze for 3 cycles.
    chk("bp_word", out_data,  8'h44);
    chk("bp_cnt",  dbg_count, 3'd1);
    or_mode = 0;
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data", out_data,   8'h44);
      chk("bp_hold_en",   out_enable, 1'b1);
      chk("bp_in_ready",  in_ready,   4'h0);
      chk("bp_hold_cnt",  dbg_count,  3'd1);
    end
    or_mode = 1;
    drive_inputs();
    cycle();
    chk("bp_resume", out_data, 8'h45);
    chk("bp_port",   out_port, 2'd1);

    // Early burst end: port 1 sends 2 words then bubbles while port 0 waits.
    all_off();
    repeat (3) cycle();
    chk("ee_idle0", busy, 1'b0);
    en_mode[1] = 3; en_lim[1] = src_seq[1] + 2;
    drive_inputs();
    cycle();
    chk("ee_grant1", dbg_grant, 2'd1);
    en_mode[0] = 1;
    drive_inputs();
    cycle();
    cycle();
    chk("ee_port1", out_port, 2'd1);
    cycle();
    chk("ee_bubble_idle", busy, 1'b0);
    cycle();
    chk("ee_busy",   busy,      1'b1);
    chk("ee_grant0", dbg_grant, 2'd0);
    cycle();
    chk("ee_out0",   out_port,  2'd0);
    chk("ee_out0_v", out_enable, 1'b1);

    // Rotation: leave last_grant at 1, then ports 1 and 3 request: 3 then 1.
    all_off();
    repeat (3) cycle();
    en_mode[1] = 3; en_lim[1] = src_seq[1] + 1;
    drive_inputs();
    cycle();
    cycle();
    cycle();
    chk("rot_idle0", busy, 1'b0);
    en_mode[1] = 1; en_mode[3] = 1;
    drive_inputs();
    cycle();
    chk("rot_grant3", dbg_grant, 2'd3);
    guard = 0;
    while (busy && guard < 20) begin
      cycle();
      guard++;
    end
    chk("rot_idle1", busy, 1'b0);
    cycle();
    chk("rot_busy",   busy,      1'b1);
    chk("rot_grant1", dbg_grant, 2'd1);

    // Random traffic checked by the model every cycle.
    for (int p = 0; p < NP; p++) en_mode[p] = 2;
    or_mode = 2;
    drive_inputs();
    repeat (2000) cycle();

    // Reset mid-burst with a word buffered.
    for (int p = 0; p < NP; p++) en_mode[p] = (p == 1 || p == 2) ? 1 : 0;
    or_mode = 1;
    drive_inputs();
    guard = 0;
    while (!(out_enable && busy) && guard < 30) begin
      cycle();
      guard++;
    end
    chk("mr_setup", out_enable & busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_out_enable", out_enable, 1'b0);
    chk("mr_out_data",   out_data,   8'h00);
    chk("mr_out_port",   out_port,   2'd0);
    chk("mr_busy",       busy,       1'b0);
    chk("mr_in_ready",   in_ready,   4'h0);
    for (int p = 0; p < NP; p++) exp_seq[p] = src_seq[p];
    @(posedge clk);
    #2;
    for (int p = 0; p < NP; p++) en_mode[p] = 1;
    reset_n = 1'b1;
    drive_inputs();
    cycle();
    chk("mr_busy_after", busy,      1'b1);
    chk("mr_grant0",     dbg_grant, 2'd0);
    cycle();
    chk("mr_first_port", out_port,   2'd0);
    chk("mr_first_en",   out_enable, 1'b1);

    all_off();
    repeat (8) cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
